fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the pipelined MIPS core. It owns the program counter and issues requests to the instruction memory over a req/ack handshake. It buffers at most one returned word while decode is stalled. It presents the fetched instruction and PC+4 to decode, where the opcode field drives the control unit, and it accepts jump/branch redirects that flush the wrong-path instruction.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, the bubble instruction,
// and the opcode field position used by both fetch and the control unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and a one-word hold buffer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | first cycle after reset, no request
//   FETCH   | request to pc outstanding
//   HOLD    | returned word parked in hold buffer, no request
//   DISCARD | wrong-path request still outstanding, its data is dropped
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [5:0]      if_id_opcode,
    output logic [PC_W-1:0] if_id_pc4
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] discard_addr_q, discard_addr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic [PC_W-1:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [PC_W-1:0] hold_pc4_q, hold_pc4_d;

    logic            if_id_accept;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] redirect_target;

    assign if_id_accept    = !if_id_valid_q || !stall;
    assign pc_plus4        = pc_q + PC_W'(4);
    // Low two bits are masked rather than sliced so every input bit is consumed.
    assign redirect_target = redirect_pc & ~PC_W'(3);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; redirect outranks stall and ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (redirect)          state_d = imem_ack ? FETCH : DISCARD;
                else if (imem_ack)     state_d = if_id_accept ? FETCH : HOLD;
            end
            HOLD: begin
                if (redirect || if_id_accept) state_d = FETCH;
            end
            // An ack retires the wrong-path request even if another redirect lands.
            DISCARD: begin
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request outputs decoded from state; the old address is held in
    // DISCARD because an issued request cannot be withdrawn.
    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == DISCARD);
        imem_addr = (state_q == DISCARD) ? discard_addr_q : pc_q;
    end

    // Datapath: pc, IF/ID register and hold buffer updates.
    always_comb begin
        pc_d           = pc_q;
        discard_addr_d = discard_addr_q;
        if_id_valid_d  = if_id_valid_q;
        if_id_instr_d  = if_id_instr_q;
        if_id_pc4_d    = if_id_pc4_q;
        hold_instr_d   = hold_instr_q;
        hold_pc4_d     = hold_pc4_q;
        if (redirect) begin
            pc_d          = redirect_target;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            if (state_q == FETCH && !imem_ack) discard_addr_d = pc_q;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4;
                        if (if_id_accept) begin
                            if_id_valid_d = 1'b1;
                            if_id_instr_d = imem_rdata;
                            if_id_pc4_d   = pc_plus4;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = pc_plus4;
                        end
                    end else if (if_id_accept) begin
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (if_id_accept) begin
                        if_id_valid_d = 1'b1;
                        if_id_instr_d = hold_instr_q;
                        if_id_pc4_d   = hold_pc4_q;
                    end
                end
                DISCARD: begin
                    if (if_id_accept) begin
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = NOP_INSTR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q           <= RESET_PC;
            discard_addr_q <= '0;
            if_id_valid_q  <= 1'b0;
            if_id_instr_q  <= NOP_INSTR;
            if_id_pc4_q    <= '0;
            hold_instr_q   <= NOP_INSTR;
            hold_pc4_q     <= '0;
        end else begin
            pc_q           <= pc_d;
            discard_addr_q <= discard_addr_d;
            if_id_valid_q  <= if_id_valid_d;
            if_id_instr_q  <= if_id_instr_d;
            if_id_pc4_q    <= if_id_pc4_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc4_q     <= hold_pc4_d;
        end
    end

    assign if_id_valid  = if_id_valid_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = if_id_instr_q[OPC_MSB:OPC_LSB];
    assign if_id_pc4    = if_id_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table for the main DUT plus a
// hand sequence for mid-request reset and pc wrap-around on a second DUT.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, stall, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;
    logic [5:0]  if_id_opcode;

    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
    logic [5:0]  w_opcode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_opcode(if_id_opcode), .if_id_pc4(if_id_pc4)
    );

    // Zero-wait memory for the wrap-around instance.
    assign w_ack   = w_req;
    assign w_rdata = w_addr + 32'h2400_0000;

    fetch_stage #(.PC_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .if_id_valid(w_valid), .if_id_instr(w_instr),
        .if_id_opcode(w_opcode), .if_id_pc4(w_pc4)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a + 32'h2400_0000;
    endfunction

    function automatic vec_t mk(input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc4, input logic ack,
                                input logic [31:0] rdata, input logic stl,
                                input logic rdr, input logic [31:0] rpc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4);
        logic [31:0] ei;
        ei = e_instr;
        chk({tag, " imem_req"},     32'(imem_req),     32'(e_req));
        chk({tag, " imem_addr"},    imem_addr,         e_addr);
        chk({tag, " if_id_valid"},  32'(if_id_valid),  32'(e_valid));
        chk({tag, " if_id_instr"},  if_id_instr,       ei);
        chk({tag, " if_id_opcode"}, 32'(if_id_opcode), 32'(ei[31:26]));
        chk({tag, " if_id_pc4"},    if_id_pc4,         e_pc4);
    endtask

    task automatic chk_wrap(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4);
        chk({tag, " w_req"},   32'(w_req),   32'(e_req));
        chk({tag, " w_addr"},  w_addr,       e_addr);
        chk({tag, " w_valid"}, 32'(w_valid), 32'(e_valid));
        chk({tag, " w_instr"}, w_instr,      e_instr);
        chk({tag, " w_pc4"},   w_pc4,        e_pc4);
    endtask

    initial begin
        // Each row: outputs expected during the cycle, then inputs applied in it.
        //            req  addr          v  instr          pc4           ack rdata          stl rdr rpc
        tbl[0]  = mk(0, 32'h000, 0, 32'h0,        32'h000, 0, 32'h0,        0, 0, 32'h0);
        tbl[1]  = mk(1, 32'h000, 0, 32'h0,        32'h000, 1, ins(32'h000), 0, 0, 32'h0);
        tbl[2]  = mk(1, 32'h004, 1, ins(32'h000), 32'h004, 1, ins(32'h004), 0, 0, 32'h0);
        tbl[3]  = mk(1, 32'h008, 1, ins(32'h004), 32'h008, 1, ins(32'h008), 0, 0, 32'h0);
        tbl[4]  = mk(1, 32'h00C, 1, ins(32'h008), 32'h00C, 0, 32'h0,        0, 0, 32'h0);
        tbl[5]  = mk(1, 32'h00C, 0, 32'h0,        32'h00C, 0, 32'h0,        0, 0, 32'h0);
        tbl[6]  = mk(1, 32'h00C, 0, 32'h0,        32'h00C, 1, ins(32'h00C), 0, 0, 32'h0);
        tbl[7]  = mk(1, 32'h010, 1, ins(32'h00C), 32'h010, 0, 32'h0,        0, 0, 32'h0);
        tbl[8]  = mk(1, 32'h010, 0, 32'h0,        32'h010, 0, 32'h0,        0, 0, 32'h0);
        tbl[9]  = mk(1, 32'h010, 0, 32'h0,        32'h010, 1, ins(32'h010), 0, 0, 32'h0);
        tbl[10] = mk(1, 32'h014, 1, ins(32'h010), 32'h014, 1, ins(32'h014), 1, 0, 32'h0);
        tbl[11] = mk(0, 32'h018, 1, ins(32'h010), 32'h014, 0, 32'h0,        1, 0, 32'h0);
        tbl[12] = mk(0, 32'h018, 1, ins(32'h010), 32'h014, 0, 32'h0,        1, 0, 32'h0);
        tbl[13] = mk(0, 32'h018, 1, ins(32'h010), 32'h014, 0, 32'h0,        0, 0, 32'h0);
        tbl[14] = mk(1, 32'h018, 1, ins(32'h014), 32'h018, 0, 32'h0,        0, 0, 32'h0);
        tbl[15] = mk(1, 32'h018, 0, 32'h0,        32'h018, 1, ins(32'h018), 0, 0, 32'h0);
        tbl[16] = mk(1, 32'h01C, 1, ins(32'h018), 32'h01C, 0, 32'h0,        0, 1, 32'h103);
        tbl[17] = mk(1, 32'h01C, 0, 32'h0,        32'h01C, 0, 32'h0,        0, 0, 32'h0);
        tbl[18] = mk(1, 32'h01C, 0, 32'h0,        32'h01C, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[19] = mk(1, 32'h100, 0, 32'h0,        32'h01C, 1, ins(32'h100), 0, 0, 32'h0);
        tbl[20] = mk(1, 32'h104, 1, ins(32'h100), 32'h104, 1, ins(32'h104), 1, 1, 32'h200);
        tbl[21] = mk(1, 32'h200, 0, 32'h0,        32'h104, 1, ins(32'h200), 0, 0, 32'h0);
        tbl[22] = mk(1, 32'h204, 1, ins(32'h200), 32'h204, 1, ins(32'h204), 1, 0, 32'h0);
        tbl[23] = mk(0, 32'h208, 1, ins(32'h200), 32'h204, 0, 32'h0,        1, 1, 32'h300);
        tbl[24] = mk(1, 32'h300, 0, 32'h0,        32'h204, 0, 32'h0,        0, 0, 32'h0);
        tbl[25] = mk(1, 32'h300, 0, 32'h0,        32'h204, 1, ins(32'h300), 1, 0, 32'h0);
        tbl[26] = mk(1, 32'h304, 1, ins(32'h300), 32'h304, 0, 32'h0,        0, 1, 32'h400);
        tbl[27] = mk(1, 32'h304, 0, 32'h0,        32'h304, 0, 32'h0,        0, 1, 32'h50E);
        tbl[28] = mk(1, 32'h304, 0, 32'h0,        32'h304, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[29] = mk(1, 32'h50C, 0, 32'h0,        32'h304, 1, ins(32'h50C), 0, 0, 32'h0);
        tbl[30] = mk(1, 32'h510, 1, ins(32'h50C), 32'h510, 0, 32'h0,        0, 0, 32'h0);
        tbl[31] = mk(1, 32'h510, 0, 32'h0,        32'h510, 0, 32'h0,        0, 0, 32'h0);

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        chk_main("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk_main($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr,
                     tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc4);
            imem_ack    = tbl[i].ack;
            imem_rdata  = tbl[i].rdata;
            stall       = tbl[i].stl;
            redirect    = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
        end

        // Reset while a request is outstanding abandons it.
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_main("midreset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("wrap_rst", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;

        chk_wrap("wrap_c0", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_wrap("wrap_c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
        chk_main("restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_wrap("wrap_c2", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h23FF_FFF8, 32'hFFFF_FFFC);
        @(negedge clk);
        chk_wrap("wrap_c3", 1'b1, 32'h0000_0000, 1'b1, 32'h23FF_FFFC, 32'h0000_0000);
        @(negedge clk);
        chk_wrap("wrap_c4", 1'b1, 32'h0000_0004, 1'b1, 32'h2400_0000, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
